// File: rtl/aes_mode_pkg.sv
// Shared types for the AES block-chaining sequencer.
// AES_MODE_CTR_EN enables CTR mode; without it a CTR request falls back to ECB.
package aes_mode_pkg;

    localparam int unsigned BlockWidth = 128;

    typedef enum logic [2:0] {
        MODE_ECB = 3'b001,
        MODE_CBC = 3'b010,
        MODE_CTR = 3'b100
    } aes_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CIN  = 2'd1,
        COUT = 2'd2,
        OUT  = 2'd3
    } aes_state_e;

    // Any mode encoding that is not a supported one-hot value runs as ECB.
    function automatic aes_mode_e mode_legalize(input logic [2:0] mode);
        case (mode)
            3'b010:  return MODE_CBC;
`ifdef AES_MODE_CTR_EN
            3'b100:  return MODE_CTR;
`endif
            default: return MODE_ECB;
        endcase
    endfunction

endpackage

// File: rtl/aes_ctr_inc.sv
// CTR counter step: low CtrWidth bits of the IV increment with wrap, upper bits held.
module aes_ctr_inc
    import aes_mode_pkg::*;
#(
    parameter int unsigned CtrWidth = 32
) (
    input  logic [BlockWidth-1:0] iv_i,
    output logic [BlockWidth-1:0] iv_inc_c
);

    logic [CtrWidth-1:0] ctr_next;

    assign ctr_next = iv_i[CtrWidth-1:0] + CtrWidth'(1);

    if (CtrWidth < BlockWidth) begin : g_part
        assign iv_inc_c = {iv_i[BlockWidth-1:CtrWidth], ctr_next};
    end else begin : g_full
        assign iv_inc_c = ctr_next;
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR chaining sequencer between the host side and aes_cipher_core.
// CTR mode and its counter exist only when AES_MODE_CTR_EN is defined.
module aes_mode_ctrl
    import aes_mode_pkg::*;
#(
    parameter int unsigned CtrWidth = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [2:0]   mode_i,
    input  logic         op_i,
    input  logic [127:0] iv_i,
    input  logic         iv_load_i,
    output logic [127:0] iv_o,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_in_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_out_o,
    output logic         busy_o,
    output logic         cipher_in_valid_o,
    input  logic         cipher_in_ready_i,
    output logic         cipher_op_o,
    output logic [127:0] cipher_state_o,
    input  logic         cipher_out_valid_i,
    output logic         cipher_out_ready_o,
    input  logic [127:0] cipher_state_i
);

    if (CtrWidth < 8 || CtrWidth > BlockWidth) begin : g_bad_ctr_width
        $error("aes_mode_ctrl: CtrWidth must be within 8..128");
    end

    aes_state_e      state_q;
    aes_mode_e       mode_q;
    aes_mode_e       mode_in;
    logic            op_q;
    logic [127:0]    data_q;
    logic [127:0]    iv_q;
    logic [127:0]    iv_eff;
    logic [127:0]    cin_next;
    logic [127:0]    result;
    logic [127:0]    iv_next;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            cin_valid_q;
    logic            cout_ready_q;
    logic            cipher_op_q;
    logic [127:0]    cipher_state_q;
    logic [127:0]    data_out_q;

`ifdef AES_MODE_CTR_EN
    logic [127:0] iv_inc;

    aes_ctr_inc #(
        .CtrWidth (CtrWidth)
    ) u_ctr_inc (
        .iv_i     (iv_q),
        .iv_inc_c (iv_inc)
    );
`endif

    assign mode_in = mode_legalize(mode_i);
    // A load in the accept cycle must already feed the new block.
    assign iv_eff  = iv_load_i ? iv_i : iv_q;

    always_comb begin
        cin_next = data_in_i;
        case (mode_in)
            MODE_CBC: cin_next = op_i ? data_in_i : (data_in_i ^ iv_eff);
`ifdef AES_MODE_CTR_EN
            MODE_CTR: cin_next = iv_eff;
`endif
            default:  cin_next = data_in_i;
        endcase
    end

    always_comb begin
        result  = cipher_state_i;
        iv_next = iv_q;
        case (mode_q)
            MODE_CBC: begin
                if (op_q) begin
                    result  = cipher_state_i ^ iv_q;
                    iv_next = data_q;
                end else begin
                    iv_next = cipher_state_i;
                end
            end
`ifdef AES_MODE_CTR_EN
            MODE_CTR: begin
                result  = data_q ^ cipher_state_i;
                iv_next = iv_inc;
            end
`endif
            default: begin
                result  = cipher_state_i;
                iv_next = iv_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            mode_q         <= MODE_ECB;
            op_q           <= 1'b0;
            data_q         <= '0;
            iv_q           <= '0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            cin_valid_q    <= 1'b0;
            cout_ready_q   <= 1'b0;
            cipher_op_q    <= 1'b0;
            cipher_state_q <= '0;
            data_out_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iv_load_i) begin
                        iv_q <= iv_i;
                    end
                    if (in_valid_i && in_ready_q) begin
                        data_q         <= data_in_i;
                        mode_q         <= mode_in;
                        op_q           <= op_i;
                        cipher_state_q <= cin_next;
                        cipher_op_q    <= (mode_in == MODE_CTR) ? 1'b0 : op_i;
                        in_ready_q     <= 1'b0;
                        cin_valid_q    <= 1'b1;
                        state_q        <= CIN;
                    end
                end
                CIN: begin
                    if (cipher_in_ready_i) begin
                        cin_valid_q  <= 1'b0;
                        cout_ready_q <= 1'b1;
                        state_q      <= COUT;
                    end
                end
                COUT: begin
                    if (cipher_out_valid_i) begin
                        data_out_q   <= result;
                        iv_q         <= iv_next;
                        cout_ready_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign iv_o               = iv_q;
    assign in_ready_o         = in_ready_q;
    assign out_valid_o        = out_valid_q;
    assign data_out_o         = data_out_q;
    assign busy_o             = (state_q != IDLE);
    assign cipher_in_valid_o  = cin_valid_q;
    assign cipher_op_o        = cipher_op_q;
    assign cipher_state_o     = cipher_state_q;
    assign cipher_out_ready_o = cout_ready_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with a reversible stand-in cipher core.
module tb_aes_mode_ctrl;

    logic         clk_i;
    logic         rst_ni;
    logic [2:0]   mode_i;
    logic         op_i;
    logic [127:0] iv_i;
    logic         iv_load_i;
    logic [127:0] iv_o;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] data_in_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] data_out_o;
    logic         busy_o;
    logic         cipher_in_valid_o;
    logic         cipher_in_ready_i;
    logic         cipher_op_o;
    logic [127:0] cipher_state_o;
    logic         cipher_out_valid_i;
    logic         cipher_out_ready_o;
    logic [127:0] cipher_state_i;

    int checks;
    int passed;

    logic         cin_rdy;
    logic         cout_gate;
    logic         pend;
    logic         last_cop;
    logic [127:0] cres;

    localparam logic [127:0] Key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    aes_mode_ctrl #(.CtrWidth(32)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .mode_i             (mode_i),
        .op_i               (op_i),
        .iv_i               (iv_i),
        .iv_load_i          (iv_load_i),
        .iv_o               (iv_o),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .data_in_i          (data_in_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .data_out_o         (data_out_o),
        .busy_o             (busy_o),
        .cipher_in_valid_o  (cipher_in_valid_o),
        .cipher_in_ready_i  (cipher_in_ready_i),
        .cipher_op_o        (cipher_op_o),
        .cipher_state_o     (cipher_state_o),
        .cipher_out_valid_i (cipher_out_valid_i),
        .cipher_out_ready_o (cipher_out_ready_o),
        .cipher_state_i     (cipher_state_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stand-in cipher: forward = rotl8 then xor key, inverse undoes it.
    function automatic logic [127:0] fwd(input logic [127:0] x);
        return {x[119:0], x[127:120]} ^ Key;
    endfunction

    function automatic logic [127:0] inv(input logic [127:0] y);
        logic [127:0] t;
        t = y ^ Key;
        return {t[7:0], t[127:8]};
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend     <= 1'b0;
            cres     <= '0;
            last_cop <= 1'b0;
        end else if (cipher_out_valid_i && cipher_out_ready_o) begin
            pend <= 1'b0;
        end else if (!pend && cipher_in_valid_o && cipher_in_ready_i) begin
            pend     <= 1'b1;
            cres     <= cipher_op_o ? inv(cipher_state_o) : fwd(cipher_state_o);
            last_cop <= cipher_op_o;
        end
    end

    assign cipher_in_ready_i  = cin_rdy;
    assign cipher_out_valid_i = pend && cout_gate;
    assign cipher_state_i     = cres;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_iv(input logic [127:0] v);
        iv_i      = v;
        iv_load_i = 1'b1;
        tick();
        iv_load_i = 1'b0;
    endtask

    // Pushes one block through and returns the host-side result.
    task automatic run_block(input logic [2:0] mode, input logic op, input logic [127:0] d,
                             input logic ld, input logic [127:0] ivv, output logic [127:0] res);
        int n;
        mode_i     = mode;
        op_i       = op;
        data_in_i  = d;
        iv_i       = ivv;
        iv_load_i  = ld;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        iv_load_i  = 1'b0;
        n = 0;
        while (!out_valid_o && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid_o !== 1'b1) $display("FAIL block_timeout out_valid=%b want 1", out_valid_o);
        else passed++;
        res = data_out_o;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready_o, out_valid_o, busy_o, cipher_in_valid_o, cipher_out_ready_o, cipher_op_o} !== 6'b100000)
            $display("FAIL reset_flags got %b want 100000",
                     {in_ready_o, out_valid_o, busy_o, cipher_in_valid_o, cipher_out_ready_o, cipher_op_o});
        else passed++;
        checks++;
        if ((iv_o | data_out_o | cipher_state_o) !== 128'h0)
            $display("FAIL reset_data iv=%h dout=%h cst=%h want 0", iv_o, data_out_o, cipher_state_o);
        else passed++;
    endtask

    task automatic test_latency();
        logic [127:0] d;
        d = 128'h00112233445566778899aabbccddeeff;
        mode_i = 3'b001; op_i = 1'b0; data_in_i = d; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        checks++;
        if ({cipher_in_valid_o, in_ready_o, busy_o} !== 3'b101)
            $display("FAIL lat_cin got %b want 101", {cipher_in_valid_o, in_ready_o, busy_o});
        else passed++;
        checks++;
        if (cipher_state_o !== d) $display("FAIL lat_cstate got %h want %h", cipher_state_o, d);
        else passed++;
        tick();
        tick();
        checks++;
        if (out_valid_o !== 1'b1) $display("FAIL lat_out got %b want 1", out_valid_o);
        else passed++;
        checks++;
        if (data_out_o !== fwd(d)) $display("FAIL lat_data got %h want %h", data_out_o, fwd(d));
        else passed++;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_ecb();
        logic [127:0] r;
        logic [127:0] ivv;
        ivv = 128'h000102030405060708090a0b0c0d0e0f;
        load_iv(ivv);
        run_block(3'b001, 1'b0, 128'h00112233445566778899aabbccddeeff, 1'b0, '0, r);
        checks++;
        if (r !== fwd(128'h00112233445566778899aabbccddeeff))
            $display("FAIL ecb_enc got %h want %h", r, fwd(128'h00112233445566778899aabbccddeeff));
        else passed++;
        run_block(3'b001, 1'b1, r, 1'b0, '0, r);
        checks++;
        if (r !== 128'h00112233445566778899aabbccddeeff)
            $display("FAIL ecb_dec got %h want 00112233445566778899aabbccddeeff", r);
        else passed++;
        run_block(3'b011, 1'b0, 128'hdeadbeef, 1'b0, '0, r);
        checks++;
        if (r !== fwd(128'hdeadbeef)) $display("FAIL ecb_badmode got %h want %h", r, fwd(128'hdeadbeef));
        else passed++;
        checks++;
        if (iv_o !== ivv) $display("FAIL ecb_iv got %h want %h", iv_o, ivv);
        else passed++;
    endtask

    task automatic test_cbc();
        logic [127:0] p [4];
        logic [127:0] c [4];
        logic [127:0] prev;
        logic [127:0] r;
        logic [127:0] ivv;
        ivv  = 128'h000102030405060708090a0b0c0d0e0f;
        p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        prev = ivv;
        for (int i = 0; i < 4; i++) begin
            c[i] = fwd(p[i] ^ prev);
            prev = c[i];
        end
        load_iv(ivv);
        for (int i = 0; i < 4; i++) begin
            run_block(3'b010, 1'b0, p[i], 1'b0, '0, r);
            checks++;
            if (r !== c[i]) $display("FAIL cbc_enc%0d got %h want %h", i, r, c[i]);
            else passed++;
        end
        checks++;
        if (iv_o !== c[3]) $display("FAIL cbc_enc_iv got %h want %h", iv_o, c[3]);
        else passed++;
        load_iv(ivv);
        for (int i = 0; i < 4; i++) begin
            run_block(3'b010, 1'b1, c[i], 1'b0, '0, r);
            checks++;
            if (r !== p[i]) $display("FAIL cbc_dec%0d got %h want %h", i, r, p[i]);
            else passed++;
        end
        checks++;
        if (iv_o !== c[3]) $display("FAIL cbc_dec_iv got %h want %h", iv_o, c[3]);
        else passed++;
    endtask

    task automatic test_ctr();
        logic [127:0] r;
        logic [127:0] ivv;
        logic [127:0] d;
        ivv = 128'h00112233445566778899aabbffffffff;
        d   = 128'hcafebabe0123456789abcdef55aa55aa;
        load_iv(ivv);
        run_block(3'b100, 1'b1, d, 1'b0, '0, r);
`ifdef AES_MODE_CTR_EN
        checks++;
        if (r !== (d ^ fwd(ivv))) $display("FAIL ctr_data got %h want %h", r, d ^ fwd(ivv));
        else passed++;
        checks++;
        if (iv_o !== 128'h00112233445566778899aabb00000000)
            $display("FAIL ctr_wrap got %h want 00112233445566778899aabb00000000", iv_o);
        else passed++;
        checks++;
        if (last_cop !== 1'b0) $display("FAIL ctr_op got %b want 0", last_cop);
        else passed++;
        run_block(3'b100, 1'b0, d, 1'b0, '0, r);
        checks++;
        if (iv_o !== 128'h00112233445566778899aabb00000001)
            $display("FAIL ctr_inc got %h want 00112233445566778899aabb00000001", iv_o);
        else passed++;
`else
        checks++;
        if (r !== inv(d)) $display("FAIL ctr_as_ecb got %h want %h", r, inv(d));
        else passed++;
        checks++;
        if (iv_o !== ivv) $display("FAIL ctr_iv_held got %h want %h", iv_o, ivv);
        else passed++;
        checks++;
        if (last_cop !== 1'b1) $display("FAIL ctr_as_ecb_op got %b want 1", last_cop);
        else passed++;
`endif
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] cs;
        logic [127:0] dout;
        logic         stable;
        int           n;
        d = 128'h0f0e0d0c0b0a09080706050403020100;
        cin_rdy = 1'b0;
        mode_i = 3'b001; op_i = 1'b0; data_in_i = d; in_valid_i = 1'b1;
        tick();
        data_in_i = 128'h1;
        cs = cipher_state_o;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cipher_state_o !== cs || in_ready_o !== 1'b0 || cipher_in_valid_o !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1 || cs !== d) $display("FAIL bp_cin stable=%b cst=%h want 1 %h", stable, cs, d);
        else passed++;
        cin_rdy = 1'b1;
        n = 0;
        while (!out_valid_o && n < 50) begin
            tick();
            n++;
        end
        dout = data_out_o;
        stable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (data_out_o !== dout || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) $display("FAIL bp_out stable=%b want 1", stable);
        else passed++;
        checks++;
        if (dout !== fwd(d)) $display("FAIL bp_data got %h want %h", dout, fwd(d));
        else passed++;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, in_ready_o} !== 2'b01) $display("FAIL bp_no_second got %b want 01", {busy_o, in_ready_o});
        else passed++;
    endtask

    task automatic test_iv_load();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] d;
        logic [127:0] r;
        int           n;
        a = 128'h11111111222222223333333344444444;
        b = 128'h99998888777766665555444433332222;
        d = 128'h0123456789abcdeffedcba9876543210;
        load_iv(a);
        cout_gate = 1'b0;
        mode_i = 3'b001; op_i = 1'b0; data_in_i = d; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n = 0;
        while (!cipher_out_ready_o && n < 50) begin
            tick();
            n++;
        end
        iv_i = b;
        iv_load_i = 1'b1;
        tick();
        tick();
        iv_load_i = 1'b0;
        checks++;
        if (iv_o !== a) $display("FAIL ivload_cout got %h want %h", iv_o, a);
        else passed++;
        cout_gate = 1'b1;
        n = 0;
        while (!out_valid_o && n < 50) begin
            tick();
            n++;
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        run_block(3'b010, 1'b0, d, 1'b1, b, r);
        checks++;
        if (r !== fwd(d ^ b)) $display("FAIL ivload_accept got %h want %h", r, fwd(d ^ b));
        else passed++;
        checks++;
        if (iv_o !== fwd(d ^ b)) $display("FAIL ivload_accept_iv got %h want %h", iv_o, fwd(d ^ b));
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] r;
        int           n;
        load_iv(128'habcdef);
        cout_gate = 1'b0;
        mode_i = 3'b010; op_i = 1'b0; data_in_i = 128'h5a5a; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n = 0;
        while (!cipher_out_ready_o && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cipher_out_ready_o !== 1'b1) $display("FAIL rst_mid_reach got %b want 1", cipher_out_ready_o);
        else passed++;
        rst_ni = 1'b0;
        tick();
        checks++;
        if ({in_ready_o, out_valid_o, busy_o, cipher_in_valid_o, cipher_out_ready_o, cipher_op_o} !== 6'b100000)
            $display("FAIL rst_mid_flags got %b want 100000",
                     {in_ready_o, out_valid_o, busy_o, cipher_in_valid_o, cipher_out_ready_o, cipher_op_o});
        else passed++;
        checks++;
        if ((iv_o | data_out_o | cipher_state_o) !== 128'h0)
            $display("FAIL rst_mid_data iv=%h dout=%h cst=%h want 0", iv_o, data_out_o, cipher_state_o);
        else passed++;
        rst_ni = 1'b1;
        cout_gate = 1'b1;
        tick();
        run_block(3'b001, 1'b0, 128'h77, 1'b0, '0, r);
        checks++;
        if (r !== fwd(128'h77)) $display("FAIL rst_mid_after got %h want %h", r, fwd(128'h77));
        else passed++;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        rst_ni      = 1'b0;
        mode_i      = 3'b001;
        op_i        = 1'b0;
        iv_i        = '0;
        iv_load_i   = 1'b0;
        in_valid_i  = 1'b0;
        data_in_i   = '0;
        out_ready_i = 1'b0;
        cin_rdy     = 1'b1;
        cout_gate   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        rst_ni = 1'b1;
        tick();
        test_reset();
        test_latency();
        test_ecb();
        test_cbc();
        test_ctr();
        test_backpressure();
        test_iv_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
